// File: rtl/mc_result_reader.sv
// Sequencer for one Monte Carlo run: clears the core, runs until the path counter reports
// completion, latches sum/sum_square and streams them to the host as an 8-word frame.
module mc_result_reader #(
  parameter logic [31:0] TIMEOUT = 32'd100000000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic        abort,
  input  logic        status,
  input  logic [63:0] sum,
  input  logic [63:0] sum_square,
  output logic        mode,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    LATCH,
    SEND
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 32'd1;

  state_t         state;
  logic [1:0]     rst_sync;
  logic           start_ok;
  logic [31:0]    run_cnt;
  logic           run_first;
  logic [2:0]     word_idx;
  logic [127:0]   shadow;
  logic           timeout_hit;

  // Reset assertion is immediate; release reaches start_ok only after two clock edges.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign start_ok    = rst_sync[1];
  assign timeout_hit = (TIMEOUT != 32'd0) && (run_cnt == TIMEOUT_LAST);
  assign busy        = (state != IDLE);

  // Frame words come only from the shadow, so the core may change sum freely during SEND.
  always_comb begin
    out_data = shadow[{word_idx, 4'b0000} +: 16];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      mode        <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      timeout_err <= 1'b0;
      run_cnt     <= '0;
      run_first   <= 1'b0;
      word_idx    <= '0;
      shadow      <= '0;
    end else if (abort) begin
      state     <= IDLE;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      run_cnt   <= '0;
      run_first <= 1'b0;
      word_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          mode      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (start && start_ok) begin
            state       <= CLEAR;
            timeout_err <= 1'b0;
          end
        end

        CLEAR: begin
          state     <= RUN;
          mode      <= 1'b1;
          run_cnt   <= '0;
          run_first <= 1'b1;
        end

        RUN: begin
          run_first <= 1'b0;
          run_cnt   <= run_cnt + 32'd1;
          if (status && !run_first) begin
            state <= LATCH;
          end else if (timeout_hit) begin
            state       <= IDLE;
            mode        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end

        LATCH: begin
          shadow    <= {sum_square, sum};
          state     <= SEND;
          mode      <= 1'b0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          word_idx  <= '0;
        end

        SEND: begin
          if (out_ready) begin
            if (word_idx == 3'd7) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              word_idx  <= '0;
            end else begin
              word_idx <= word_idx + 3'd1;
              out_last <= (word_idx == 3'd6);
            end
          end
        end

        default: begin
          state     <= IDLE;
          mode      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          word_idx  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_result_reader.sv
// Scoreboard bench for mc_result_reader: expected frame words are queued when a run is
// launched and popped by a monitor on every host handshake.
module tb_mc_result_reader;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        status = 1'b0;
  logic [63:0] sum = '0;
  logic [63:0] sum_square = '0;
  logic        out_ready = 1'b0;
  logic        mode, out_valid, out_last, busy, timeout_err;
  logic [15:0] out_data;

  logic        start_to = 1'b0;
  logic        status_to = 1'b0;
  logic        mode_to, out_valid_to, out_last_to, busy_to, timeout_err_to;
  logic [15:0] out_data_to;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  logic        stall_pend = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;

  always #5 clk = ~clk;

  mc_result_reader dut (
    .clk        (clk),
    .nreset     (nreset),
    .start      (start),
    .abort      (abort),
    .status     (status),
    .sum        (sum),
    .sum_square (sum_square),
    .mode       (mode),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  mc_result_reader #(.TIMEOUT(32'd50)) dut_to (
    .clk        (clk),
    .nreset     (nreset),
    .start      (start_to),
    .abort      (abort),
    .status     (status_to),
    .sum        (sum),
    .sum_square (sum_square),
    .mode       (mode_to),
    .out_data   (out_data_to),
    .out_valid  (out_valid_to),
    .out_ready  (1'b1),
    .out_last   (out_last_to),
    .busy       (busy_to),
    .timeout_err(timeout_err_to)
  );

  // Handshake monitor: pops the scoreboard and checks stall stability, sampled mid-cycle.
  always @(negedge clk) begin
    word_t w;
    if (!nreset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && out_valid === 1'b1) begin
        checks++;
        if (out_data !== stall_data || out_last !== stall_last) begin
          errors++;
          $display("FAIL stall_hold: data=%h last=%b, required data=%h last=%b",
                   out_data, out_last, stall_data, stall_last);
        end
      end
      stall_pend = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: data=%h last=%b, required no word", out_data, out_last);
        end else begin
          w = exp_q.pop_front();
          if (out_data !== w.data || out_last !== w.last) begin
            errors++;
            $display("FAIL frame_word: data=%h last=%b, required data=%h last=%b",
                     out_data, out_last, w.data, w.last);
          end
        end
      end else if (out_valid === 1'b1) begin
        stall_pend = 1'b1;
        stall_data = out_data;
        stall_last = out_last;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [63:0] s, input logic [63:0] sq);
    logic [127:0] f;
    word_t w;
    f = {sq, s};
    for (int i = 0; i < 8; i++) begin
      w.data = f[i*16 +: 16];
      w.last = (i == 7);
      exp_q.push_back(w);
    end
  endtask

  task automatic launch(input int run_cycles);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(run_cycles);
    status = 1'b1;
    step(1);
    status = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_idle(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step(1);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({mode, out_valid, out_last, busy, timeout_err} !== 5'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: mode=%b valid=%b last=%b busy=%b terr=%b data=%h, required all 0",
               mode, out_valid, out_last, busy, timeout_err, out_data);
    end
    step(2);
    nreset = 1'b1;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_start1: busy=%b, required 0", busy);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_start2: busy=%b, required 0", busy);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_start3: busy=%b, required 1", busy);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] golden [8];
    word_t w;
    int vcyc;
    golden = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    for (int i = 0; i < 8; i++) begin
      w.data = golden[i];
      w.last = (i == 7);
      exp_q.push_back(w);
    end
    sum        = 64'h0123_4567_89AB_CDEF;
    sum_square = 64'hFEDC_BA98_7654_3210;
    out_ready  = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (mode !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_clear: mode=%b busy=%b, required mode=0 busy=1", mode, busy);
    end
    step(1);
    checks++;
    if (mode !== 1'b1) begin
      errors++;
      $display("FAIL basic_run_mode: mode=%b, required 1", mode);
    end
    step(100);
    status = 1'b1;
    step(1);
    status = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mode !== 1'b1) begin
      errors++;
      $display("FAIL basic_latch: valid=%b mode=%b, required valid=0 mode=1", out_valid, mode);
    end
    step(1);
    checks++;
    if (out_valid !== 1'b1 || mode !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: valid=%b mode=%b, required valid=1 mode=0", out_valid, mode);
    end
    vcyc = 0;
    for (int i = 0; i < 20 && out_valid === 1'b1; i++) begin
      vcyc++;
      step(1);
    end
    checks++;
    if (vcyc != 8 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_frame_len: cycles=%0d busy=%b left=%0d, required cycles=8 busy=0 left=0",
               vcyc, busy, exp_q.size());
    end
  endtask

  task automatic test_stall;
    bit ok;
    int vcyc;
    sum        = 64'h0123_4567_89AB_CDEF;
    sum_square = 64'hFEDC_BA98_7654_3210;
    push_frame(sum, sum_square);
    out_ready = 1'b0;
    launch(5);
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_first_valid: valid=%b, required 1 within budget", out_valid);
    end
    sum        = 64'hDEAD_BEEF_0BAD_F00D;
    sum_square = 64'h1111_2222_3333_4444;
    vcyc = 0;
    for (int c = 0; c < 60 && out_valid === 1'b1; c++) begin
      out_ready = (c % 3 == 0);
      vcyc++;
      step(1);
    end
    out_ready = 1'b0;
    checks++;
    if (vcyc != 22 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_frame: cycles=%0d busy=%b left=%0d, required cycles=22 busy=0 left=0",
               vcyc, busy, exp_q.size());
    end
  endtask

  task automatic test_timeout;
    int  mcnt;
    bit  seen_valid;
    start_to = 1'b1;
    step(1);
    start_to = 1'b0;
    mcnt = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (mode_to === 1'b1) mcnt++;
      if (out_valid_to === 1'b1) seen_valid = 1'b1;
      if (busy_to === 1'b0) break;
    end
    checks++;
    if (mcnt != 50 || timeout_err_to !== 1'b1 || seen_valid || mode_to !== 1'b0 || busy_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_run: mode_cycles=%0d terr=%b valid_seen=%b mode=%b busy=%b, required 50 1 0 0 0",
               mcnt, timeout_err_to, seen_valid, mode_to, busy_to);
    end
    start_to = 1'b1;
    abort    = 1'b1;
    step(1);
    start_to = 1'b0;
    abort    = 1'b0;
    checks++;
    if (busy_to !== 1'b0 || timeout_err_to !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort_wins: busy=%b terr=%b, required busy=0 terr=1", busy_to, timeout_err_to);
    end
    start_to = 1'b1;
    step(1);
    start_to = 1'b0;
    checks++;
    if (busy_to !== 1'b1 || timeout_err_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: busy=%b terr=%b, required busy=1 terr=0", busy_to, timeout_err_to);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
  endtask

  task automatic test_abort;
    bit ok;
    int cyc;
    logic [63:0] a;
    a = 64'hA5A5_1234_5A5A_9876;
    sum        = a;
    sum_square = 64'h0F0F_2468_F0F0_1357;
    push_frame(sum, sum_square);
    out_ready = 1'b1;
    launch(4);
    wait_valid(10, ok);
    step(3);
    checks++;
    if (!ok || out_valid !== 1'b1 || out_data !== a[63:48]) begin
      errors++;
      $display("FAIL abort_word3: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, a[63:48]);
    end
    abort     = 1'b1;
    out_ready = 1'b0;
    step(1);
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mode !== 1'b0 || out_last !== 1'b0 || exp_q.size() != 5) begin
      errors++;
      $display("FAIL abort_idle: valid=%b busy=%b mode=%b last=%b left=%0d, required 0 0 0 0 5",
               out_valid, busy, mode, out_last, exp_q.size());
    end
    exp_q.delete();
    sum        = 64'h1357_9BDF_2468_ACE0;
    sum_square = 64'h0000_FFFF_AAAA_5555;
    push_frame(sum, sum_square);
    out_ready = 1'b1;
    launch(3);
    wait_idle(30, cyc, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_next_frame: idle=%b left=%0d, required idle=1 left=0", ok, exp_q.size());
    end
  endtask

  task automatic test_ignore;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      step(1);
      start = 1'b0;
      checks++;
      if (mode !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ignore_start_run%0d: mode=%b busy=%b valid=%b, required 1 1 0", i, mode, busy, out_valid);
      end
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      status = ~status;
      step(1);
      checks++;
      if (mode !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ignore_status_idle%0d: mode=%b busy=%b valid=%b, required 0 0 0", i, mode, busy, out_valid);
      end
    end
    status = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int cyc;
    status    = 1'b1;
    out_ready = 1'b1;
    sum        = 64'h7777_6666_5555_4444;
    sum_square = 64'h3333_2222_1111_0000;
    push_frame(sum, sum_square);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    checks++;
    if (out_valid !== 1'b0 || mode !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_run_skip: valid=%b mode=%b, required valid=0 mode=1", out_valid, mode);
    end
    step(1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_latency: valid=%b, required 1", out_valid);
    end
    wait_idle(20, cyc, ok);
    sum        = 64'h8899_AABB_CCDD_EEFF;
    sum_square = 64'h0102_0304_0506_0708;
    push_frame(sum, sum_square);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle(30, cyc, ok);
    status = 1'b0;
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_frames: idle=%b left=%0d, required idle=1 left=0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_send;
    bit ok;
    sum        = 64'hCAFE_BABE_F00D_FACE;
    sum_square = 64'h9999_8888_7777_6666;
    push_frame(sum, sum_square);
    out_ready = 1'b0;
    launch(3);
    wait_valid(10, ok);
    step(2);
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (!ok || {mode, out_valid, out_last, busy, timeout_err} !== 5'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_send: sent=%b mode=%b valid=%b last=%b busy=%b terr=%b data=%h, required sent=1 rest 0",
               ok, mode, out_valid, out_last, busy, timeout_err, out_data);
    end
    checks++;
    if (exp_q.size() != 8) begin
      errors++;
      $display("FAIL reset_mid_send_words: accepted=%0d, required 0", 8 - exp_q.size());
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    step(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_abort();
    test_ignore();
    test_back_to_back();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
